// File: rtl/ahb_to_axi4lite_bridge.sv
// ---------------------------------------------------------------------------
// ahb_to_axi4lite_bridge
//
// AHB-Lite slave to AXI4-Lite master bridge. Each accepted AHB transfer is
// issued as one AXI4-Lite read or write. Only one transfer is in flight at a
// time. AHB wait states are inserted until the AXI response returns. A
// non-zero BRESP/RRESP becomes the two-cycle AHB ERROR response.
//
// Ports
//   clk, rst        : single clock, synchronous active-high reset
//   s_h*            : AHB-Lite slave port (s_hrdata/s_hresp/s_hreadyout out)
//   m_aw*, m_w*     : AXI4-Lite write address / write data channels
//   m_b*            : AXI4-Lite write response channel
//   m_ar*, m_r*     : AXI4-Lite read address / read data channels
//
// Configuration
//   AHB2AXIL_ALIGN_CHECK_EN : when defined, accesses with hsize==3, odd
//   halfword addresses or non-word-aligned word addresses are answered with
//   an AHB ERROR and generate no AXI traffic. When undefined, hsize==3 is
//   issued as a word and misaligned accesses use the normal strobe rule.
// ---------------------------------------------------------------------------
module ahb_to_axi4lite_bridge (
    input  logic        clk,
    input  logic        rst,
    // AHB-Lite slave
    input  logic [31:0] s_haddr,
    input  logic [1:0]  s_hsize,
    input  logic [1:0]  s_htrans,
    input  logic        s_hwrite,
    input  logic        s_hsel,
    input  logic        s_hready,
    input  logic [3:0]  s_hprot,
    input  logic [31:0] s_hwdata,
    output logic [31:0] s_hrdata,
    output logic        s_hresp,
    output logic        s_hreadyout,
    // AXI4-Lite master: write
    output logic [31:0] m_awaddr,
    output logic [2:0]  m_awprot,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    // AXI4-Lite master: read
    output logic [31:0] m_araddr,
    output logic [2:0]  m_arprot,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_WDATA = 4'd1,
        ST_WADDR = 4'd2,
        ST_WRESP = 4'd3,
        ST_RADDR = 4'd4,
        ST_RRESP = 4'd5,
        ST_DONE  = 4'd6,
        ST_ERR1  = 4'd7,
        ST_ERR2  = 4'd8
    } state_t;

    state_t      state_r;
    logic [31:0] addr_r;
    logic [1:0]  size_r;
    logic [2:0]  prot_r;

    logic        accept_s;
    logic [2:0]  prot_map_s;
    logic        bad_access_s;
    logic        unused_s;

    // Byte lanes touched by an access; size 3 falls back to a full word.
    function automatic logic [3:0] calc_wstrb(input logic [1:0] size, input logic [1:0] lsb);
        logic [3:0] strb;
        case (size)
            2'd0:    strb = 4'b0001 << lsb;
            2'd1:    strb = 4'b0011 << {lsb[1], 1'b0};
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

`ifdef AHB2AXIL_ALIGN_CHECK_EN
    // True for hsize==3 or an address not aligned to the access size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = lsb[0];
            2'd2:    bad = (lsb != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign bad_access_s = is_misaligned(s_hsize, s_haddr[1:0]);
`else
    assign bad_access_s = 1'b0;
`endif

    assign accept_s   = s_hsel & s_hready & s_htrans[1];
    // AXI prot: [0] privileged = hprot[1], [1] secure (0), [2] instruction = ~hprot[0]
    assign prot_map_s = {~s_hprot[0], 1'b0, s_hprot[1]};
    // hprot bufferable/cacheable bits have no AXI4-Lite counterpart.
    assign unused_s   = &{1'b0, s_hprot[3:2]};

    // Bridge FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            addr_r      <= 32'h0000_0000;
            size_r      <= 2'b00;
            prot_r      <= 3'b000;
            s_hrdata    <= 32'h0000_0000;
            s_hresp     <= 1'b0;
            s_hreadyout <= 1'b1;
            m_awaddr    <= 32'h0000_0000;
            m_awprot    <= 3'b000;
            m_awvalid   <= 1'b0;
            m_wdata     <= 32'h0000_0000;
            m_wstrb     <= 4'b0000;
            m_wvalid    <= 1'b0;
            m_bready    <= 1'b0;
            m_araddr    <= 32'h0000_0000;
            m_arprot    <= 3'b000;
            m_arvalid   <= 1'b0;
            m_rready    <= 1'b0;
        end else begin
            case (state_r)
                // Ready states: a new address phase may be accepted here,
                // including the pipelined one in DONE/ERR2.
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    s_hreadyout <= 1'b1;
                    s_hresp     <= 1'b0;
                    if (accept_s) begin
                        addr_r <= s_haddr;
                        size_r <= s_hsize;
                        prot_r <= prot_map_s;
                        if (bad_access_s) begin
                            state_r     <= ST_ERR1;
                            s_hreadyout <= 1'b0;
                            s_hresp     <= 1'b1;
                        end else if (s_hwrite) begin
                            state_r     <= ST_WDATA;
                            s_hreadyout <= 1'b0;
                        end else begin
                            state_r     <= ST_RADDR;
                            s_hreadyout <= 1'b0;
                            m_araddr    <= s_haddr;
                            m_arprot    <= prot_map_s;
                            m_arvalid   <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                // AHB data phase: write data is only valid now.
                ST_WDATA: begin
                    m_wdata   <= s_hwdata;
                    m_wstrb   <= calc_wstrb(size_r, addr_r[1:0]);
                    m_awaddr  <= addr_r;
                    m_awprot  <= prot_r;
                    m_awvalid <= 1'b1;
                    m_wvalid  <= 1'b1;
                    state_r   <= ST_WADDR;
                end

                // AW and W complete independently; a low valid means done.
                ST_WADDR: begin
                    if (m_awvalid && m_awready) begin
                        m_awvalid <= 1'b0;
                    end
                    if (m_wvalid && m_wready) begin
                        m_wvalid <= 1'b0;
                    end
                    if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
                        m_bready <= 1'b1;
                        state_r  <= ST_WRESP;
                    end
                end

                ST_WRESP: begin
                    if (m_bvalid) begin
                        m_bready <= 1'b0;
                        if (m_bresp == 2'b00) begin
                            state_r     <= ST_DONE;
                            s_hreadyout <= 1'b1;
                        end else begin
                            state_r <= ST_ERR1;
                            s_hresp <= 1'b1;
                        end
                    end
                end

                ST_RADDR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state_r   <= ST_RRESP;
                    end
                end

                // Read data is returned even when the response is an error.
                ST_RRESP: begin
                    if (m_rvalid) begin
                        m_rready <= 1'b0;
                        s_hrdata <= m_rdata;
                        if (m_rresp == 2'b00) begin
                            state_r     <= ST_DONE;
                            s_hreadyout <= 1'b1;
                        end else begin
                            state_r <= ST_ERR1;
                            s_hresp <= 1'b1;
                        end
                    end
                end

                // First ERROR cycle (hready low); second cycle raises hready.
                ST_ERR1: begin
                    s_hreadyout <= 1'b1;
                    s_hresp     <= 1'b1;
                    state_r     <= ST_ERR2;
                end

                default: begin
                    state_r     <= ST_IDLE;
                    s_hreadyout <= 1'b1;
                    s_hresp     <= 1'b0;
                    m_awvalid   <= 1'b0;
                    m_wvalid    <= 1'b0;
                    m_bready    <= 1'b0;
                    m_arvalid   <= 1'b0;
                    m_rready    <= 1'b0;
                end
            endcase
        end
    end

endmodule
